// File: rtl/coord_seq_pkg.sv
// Shared types and widths for the coordinate sequencer and the LED blinker.
package coord_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      GAP
   } coord_seq_state_t;

   localparam int unsigned COORD_W     = 7;
   localparam int unsigned FRAME_CNT_W = 8;
   localparam int unsigned GAP_CNT_W   = 16;

endpackage

// File: rtl/coord_stepper.sv
// Holds the current (col,row) and computes the next/last coordinate.
// Serpentine order is selected with COORD_SEQ_SERPENTINE_EN; raster order otherwise.
module coord_stepper
   import coord_seq_pkg::*;
#(
   parameter int unsigned NCOL = 8,
   parameter int unsigned NROW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               advance,
   output logic [COORD_W-1:0] col,
   output logic [COORD_W-1:0] row,
   output logic               last
);

   localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(NCOL - 1);
   localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(NROW - 1);

   logic [COORD_W-1:0] end_col;
   logic [COORD_W-1:0] next_col;
   logic [COORD_W-1:0] next_row;
   logic               at_end;

   always_comb begin
      end_col  = COL_LAST;
      next_col = col;
      next_row = row;
`ifdef COORD_SEQ_SERPENTINE_EN
      // odd rows run right-to-left, so they finish at column 0
      end_col = row[0] ? '0 : COL_LAST;
`endif
      at_end = (col == end_col);
      last   = at_end && (row == ROW_LAST);
      if (at_end) begin
         next_row = row + 1'b1;
`ifdef COORD_SEQ_SERPENTINE_EN
         next_col = next_row[0] ? COL_LAST : '0;
`else
         next_col = '0;
`endif
      end else begin
`ifdef COORD_SEQ_SERPENTINE_EN
         next_col = row[0] ? col - 1'b1 : col + 1'b1;
`else
         next_col = col + 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         col <= next_col;
         row <= next_row;
      end
   end

endmodule

// File: rtl/coord_sequencer.sv
// Walks a NCOL x NROW grid, holding each coordinate for REPEATS frames then a blank gap.
// Optional serpentine scan order: define COORD_SEQ_SERPENTINE_EN.
module coord_sequencer
   import coord_seq_pkg::*;
#(
   parameter int unsigned NCOL       = 8,
   parameter int unsigned NROW       = 8,
   parameter int unsigned REPEATS    = 2,
   parameter int unsigned GAP_CYCLES = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   input  logic               frame_done,
   output logic [COORD_W-1:0] col,
   output logic [COORD_W-1:0] row,
   output logic               blank,
   output logic               busy,
   output logic               done
);

   localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(REPEATS - 1);
   localparam logic [GAP_CNT_W-1:0]   GAP_LAST   = (GAP_CYCLES == 0) ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);
   localparam bit                     NO_GAP     = (GAP_CYCLES == 0);

   coord_seq_state_t       state;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [GAP_CNT_W-1:0]   gap_cnt;
   logic                   step;
   logic                   last;
   logic                   clear;
   logic                   advance;

   coord_stepper #(
      .NCOL(NCOL),
      .NROW(NROW)
   ) u_stepper (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .advance(advance),
      .col    (col),
      .row    (row),
      .last   (last)
   );

   // step marks the ADVANCE edge; the grid end maps to a clear instead of an increment
   always_comb begin
      step = 1'b0;
      case (state)
         WAIT:    step = NO_GAP && frame_done && (frame_cnt == FRAME_LAST);
         GAP:     step = (gap_cnt == GAP_LAST);
         default: step = 1'b0;
      endcase
      clear   = stop || ((state == IDLE) && start) || (step && last);
      advance = step && !last && !stop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_cnt <= '0;
         gap_cnt   <= '0;
         blank     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state     <= IDLE;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            blank     <= 1'b1;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state     <= WAIT;
                     frame_cnt <= '0;
                     blank     <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
               WAIT: begin
                  if (frame_done) begin
                     if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        if (!NO_GAP) begin
                           state   <= GAP;
                           gap_cnt <= '0;
                           blank   <= 1'b1;
                        end
                     end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                     end
                  end
               end
               GAP: begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
               default: state <= IDLE;
            endcase
            if (step) begin
               gap_cnt <= '0;
               if (last && !loop) begin
                  state <= IDLE;
                  blank <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= WAIT;
                  blank <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: doc/coord_sequencer.md
# coord_sequencer

Upstream driver for the LED coordinate blinker. It walks a configurable grid of (col, row) coordinates and presents each one as a stable 7-bit pair to the blinker. Each coordinate is held for a fixed number of blinker frames, followed by a blanking gap. Advancement is paced by a one-cycle `frame_done` pulse returned from the downstream stage, so the sequencer never changes a coordinate mid-frame.

## Interface
Parameters:
- `NCOL`, 8, number of columns scanned; legal range 1..127.
- `NROW`, 8, number of rows scanned; legal range 1..127.
- `REPEATS`, 2, frames per coordinate; legal range 1..255.
- `GAP_CYCLES`, 256, blank cycles between coordinates; legal range 0..65535.

Ports (one clock; reset is asynchronous, active-low):
- `clk`  in  1  system clock, shared with the blinker.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level-sampled; starts a scan from IDLE.
- `stop`  in  1  level-sampled; aborts the scan.
- `loop`  in  1  sampled at end of grid; 1 restarts at (0,0), 0 finishes.
- `frame_done`  in  1  one-cycle pulse from the blinker at frame wrap.
- `col`  out  7  current column.
- `row`  out  7  current row.
- `blank`  out  1  1 means the downstream LED must be forced off.
- `busy`  out  1  1 in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a non-looping scan completes.

## Operation
- FSM states: IDLE, WAIT, GAP.
- IDLE
  - Outputs: col=0, row=0, blank=1, busy=0.
  - `start`=1 and `stop`=0 → WAIT, with col=0, row=0, frame counter=0.
- WAIT
  - blank=0.
  - Each `frame_done` increments an 8-bit frame counter.
  - The pulse that makes the count reach REPEATS → GAP, or goes straight to ADVANCE if GAP_CYCLES=0. The frame counter clears on this transition.
- GAP
  - blank=1; a 16-bit counter runs GAP_CYCLES cycles.
  - `frame_done` is ignored.
  - On the final gap cycle → ADVANCE.
- ADVANCE (a transition action, not a state)
  - col increments.
  - At col=NCOL-1, col wraps to 0 and row increments.
  - At (NCOL-1, NROW-1):
    - `loop`=1 → (0,0), WAIT.
    - `loop`=0 → IDLE, `done` pulses for 1 cycle.
  - Otherwise → WAIT with the new coordinate.
- `stop`=1 in any state → IDLE on the next edge. `done` is not asserted.
- Simultaneous `start` and `stop` in IDLE: `stop` wins; the block stays in IDLE.
- `frame_done` in IDLE is ignored.
- `start` while busy is ignored.
- col/row change only on the ADVANCE edge or on a reset/abort edge. They are stable throughout WAIT.

## Timing
- Reset values: col=0, row=0, blank=1, busy=0, done=0, state IDLE, all counters 0.
- Asynchronous reset mid-scan returns everything to reset values immediately.
- All outputs are registered.
- `start` sampled at edge N → busy=1, blank=0 after edge N.
- `frame_done` at edge N that completes REPEATS:
  - blank=1 after edge N.
  - The new coordinate appears after edge N+GAP_CYCLES.
  - blank=0 after that same edge.
- GAP_CYCLES=0: the coordinate changes after edge N and blank stays 0.
- `done` is high for exactly the one cycle after the edge that enters IDLE from the end of grid.

## Configuration
- Macro `COORD_SEQ_SERPENTINE_EN`.
- Defined: on odd rows, col counts down from NCOL-1 to 0; on even rows, col counts up from 0. The row step occurs at the end column of each row. For odd NROW the last coordinate is (NCOL-1, NROW-1); for even NROW it is (0, NROW-1). With `loop`=1 the scan wraps to (0,0).
- Undefined: raster order as described in Operation; col always counts up.

## Structure
- Shared package `coord_seq_pkg`:
  - state enum `coord_seq_state_t` (IDLE, WAIT, GAP);
  - `COORD_W`=7;
  - `FRAME_CNT_W`=8;
  - `GAP_CNT_W`=16.
- The blinker imports `COORD_W` from the same package.
- One sub-module, `coord_stepper`: holds col/row and implements the raster/serpentine next-coordinate and last-coordinate logic.
- The FSM and counters stay in the top module.

## Test plan
1. Reset, NCOL=2, NROW=2, REPEATS=1, GAP_CYCLES=4, start=1 for 1 cycle, loop=0, frame_done pulsed every 20 cycles → coordinates (0,0), (1,0), (0,1), (1,1), in that order. Each changes exactly 4 cycles after its frame_done. `done` pulses once; busy=0 afterwards.
2. REPEATS=3 → coordinate changes only after the 3rd frame_done. frame_done pulses injected during GAP do not shorten or extend the hold.
3. Assert stop during the GAP of (1,0) → next cycle col=0, row=0, blank=1, busy=0; `done` never asserts.
4. loop=1, NCOL=NROW=2 → after (1,1) the sequence returns to (0,0) with no `done` pulse. start+stop asserted together in IDLE → stays in IDLE.
5. GAP_CYCLES=0 → blank stays 0 while busy; the coordinate changes on the cycle after frame_done.
6. With COORD_SEQ_SERPENTINE_EN, NCOL=3, NROW=2 → (0,0), (1,0), (2,0), (2,1), (1,1), (0,1), then done. Drop rst_n mid-scan → all outputs at reset values immediately.
